// File: rtl/pb_toggle_ctrl.sv
// Four-channel push-button front end: synchronise, debounce, detect presses and
// keep a per-group toggle mask that gates the downstream LED groups.
module pb_toggle_ctrl #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       clr_all,
  output logic [3:0] btn_stable,
  output logic [3:0] press,
  output logic [3:0] mask
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [CW-1:0] cnt [4];
  logic [3:0]    accept;
  logic [3:0]    rise;

  // A channel is accepted once sync2 has disagreed with btn_stable on DB_CYCLES
  // consecutive edges; only the 0->1 acceptances count as presses.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      accept[i] = (sync2[i] != btn_stable[i]) && (cnt[i] == CNT_MAX);
    end
    rise = accept & sync2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      btn_stable <= '0;
      press      <= '0;
      mask       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= btn;
      sync2      <= sync1;
      btn_stable <= btn_stable ^ accept;
      press      <= rise;
      mask       <= clr_all ? '0 : (mask ^ rise);
      for (int unsigned i = 0; i < 4; i++) begin
        if ((sync2[i] == btn_stable[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pb_toggle_ctrl.sv
// Self-checking bench for pb_toggle_ctrl: directed scenarios plus randomized
// traffic compared against a window-based behavioural model.
module tb_pb_toggle_ctrl;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic       clr_all = 1'b0;
  logic [3:0] btn_stable;
  logic [3:0] press;
  logic [3:0] mask;

  int checks = 0;
  int failures = 0;

  pb_toggle_ctrl #(.DB_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .clr_all    (clr_all),
    .btn_stable (btn_stable),
    .press      (press),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  // Behavioural model: a level is accepted when the last DB synchronised
  // samples all disagree with the accepted level.
  logic [3:0] m_s1, m_s2, m_stable, m_press, m_mask;
  logic [3:0] hist [$];
  logic [3:0] m_flip, m_rise, m_h;
  logic       m_all;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0; m_mask = '0;
      hist.delete();
    end else begin
      hist.push_front(m_s2);
      if (hist.size() > DB) void'(hist.pop_back());
      m_flip = '0;
      if (hist.size() == DB) begin
        for (int i = 0; i < 4; i++) begin
          m_all = 1'b1;
          for (int j = 0; j < hist.size(); j++) begin
            m_h = hist[j];
            if (m_h[i] == m_stable[i]) m_all = 1'b0;
          end
          m_flip[i] = m_all;
        end
      end
      m_rise   = m_flip & ~m_stable;
      m_stable = m_stable ^ m_flip;
      m_press  = m_rise;
      m_mask   = clr_all ? 4'b0000 : (m_mask ^ m_rise);
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  task automatic do_reset();
    rst = 1'b1; btn = '0; clr_all = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = '0; clr_all = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({btn_stable, press, mask} !== 12'h000) begin
        failures++;
        $display("FAIL reset_outputs: got stable=%b press=%b mask=%b expected all 0",
                 btn_stable, press, mask);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_press_timing();
    do_reset();
    btn = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      checks++;
      if (e < 6) begin
        if (btn_stable !== 4'b0000 || mask !== 4'b0000 || press !== 4'b0000) begin
          failures++;
          $display("FAIL press_early e=%0d: got stable=%b press=%b mask=%b expected 0000",
                   e, btn_stable, press, mask);
        end
      end else if (btn_stable !== 4'b0001 || press !== 4'b0001 || mask !== 4'b0001) begin
        failures++;
        $display("FAIL press_accept: got stable=%b press=%b mask=%b expected 0001 each",
                 btn_stable, press, mask);
      end
    end
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      checks++;
      if (btn_stable !== 4'b0001 || press !== 4'b0000 || mask !== 4'b0001) begin
        failures++;
        $display("FAIL press_held: got stable=%b press=%b mask=%b expected 0001/0000/0001",
                 btn_stable, press, mask);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btn = 4'b0100;
    repeat (3) @(negedge clk);
    btn = 4'b0000;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      checks++;
      if ({btn_stable, press, mask} !== 12'h000) begin
        failures++;
        $display("FAIL glitch_reject: got stable=%b press=%b mask=%b expected all 0",
                 btn_stable, press, mask);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic prev_m;
    logic [3:0] seq;
    int nseq;
    pulses = 0; nseq = 0; seq = '0;
    do_reset();
    prev_m = mask[1];
    for (int r = 0; r < 2; r++) begin
      for (int ph = 0; ph < 2; ph++) begin
        btn = (ph == 0) ? 4'b0010 : 4'b0000;
        repeat (9) begin
          @(negedge clk);
          if (press[1]) pulses++;
          if (mask[1] !== prev_m && nseq < 4) begin
            seq[nseq] = mask[1];
            nseq++;
          end
          prev_m = mask[1];
        end
      end
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL two_press_pulses: got %0d expected 2", pulses);
    end
    checks++;
    if (nseq !== 2 || seq[1:0] !== 2'b01) begin
      failures++;
      $display("FAIL two_press_mask_seq: got n=%0d seq=%b expected n=2 seq=01 (1 then 0)",
               nseq, seq[1:0]);
    end
  endtask

  task automatic test_clr_priority();
    do_reset();
    btn = 4'b1111;
    repeat (5) @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    checks++;
    if (mask !== 4'b0000 || press !== 4'b1111 || btn_stable !== 4'b1111) begin
      failures++;
      $display("FAIL clr_on_accept: got stable=%b press=%b mask=%b expected 1111/1111/0000",
               btn_stable, press, mask);
    end
    clr_all = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (mask !== 4'b0000 || press !== 4'b0000) begin
        failures++;
        $display("FAIL clr_held: got press=%b mask=%b expected 0000/0000", press, mask);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    btn = 4'b1000;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({btn_stable, press, mask} !== 12'h000) begin
        failures++;
        $display("FAIL rst_mid_outputs: got stable=%b press=%b mask=%b expected all 0",
                 btn_stable, press, mask);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      checks++;
      if (e < 6) begin
        if (btn_stable !== 4'b0000 || mask !== 4'b0000) begin
          failures++;
          $display("FAIL rst_release_early e=%0d: got stable=%b mask=%b expected 0000",
                   e, btn_stable, mask);
        end
      end else if (btn_stable !== 4'b1000 || mask !== 4'b1000 || press !== 4'b1000) begin
        failures++;
        $display("FAIL rst_release_accept: got stable=%b press=%b mask=%b expected 1000 each",
                 btn_stable, press, mask);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      btn  = 4'($urandom);
      hold = int'($urandom_range(1, 8));
      for (int c = 0; c < hold; c++) begin
        clr_all = ($urandom_range(0, 15) == 0);
        rst     = ($urandom_range(0, 149) == 0);
        @(negedge clk);
        checks++;
        if (btn_stable !== m_stable || press !== m_press || mask !== m_mask) begin
          failures++;
          $display("FAIL random_model: got stable=%b press=%b mask=%b expected %b/%b/%b",
                   btn_stable, press, mask, m_stable, m_press, m_mask);
        end
      end
    end
    rst = 1'b0; clr_all = 1'b0; btn = '0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_timing();
    test_back_to_back();
    test_clr_priority();
    test_reset_mid_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pb_toggle_ctrl.md
PB_TOGGLE_CTRL -- requirements
Module: pb_toggle_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive stable cycles before a button level is accepted; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port btn  input  4  raw asynchronous push buttons, bit i controls LED group i (group i = LEDs 4i..4i+3).
REQ-005 SHALL have port clr_all  input  1  synchronous request to clear all mask bits.
REQ-006 SHALL have port btn_stable  output  4  debounced button level.
REQ-007 SHALL have port press  output  4  one-cycle pulse per accepted press.
REQ-008 SHALL have port mask  output  4  toggle state per group, 1 = group forced off; drives the downstream LED gating stage directly.
REQ-009 SHALL use one clock and a synchronous, active-high reset; no other clocks or async resets.

Function
REQ-010 SHALL pass each btn bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL hold per bit a counter cnt of width clog2(DB_CYCLES).
REQ-012 SHALL, each edge where sync2[i] == btn_stable[i], load cnt[i] with 0.
REQ-013 SHALL, each edge where sync2[i] != btn_stable[i] and cnt[i] < DB_CYCLES-1, increment cnt[i].
REQ-014 SHALL, each edge where sync2[i] != btn_stable[i] and cnt[i] == DB_CYCLES-1, load btn_stable[i] with sync2[i] and cnt[i] with 0.
REQ-015 SHALL, for a raw change captured by sync1 at edge k and held, update btn_stable at edge k+1+DB_CYCLES.
REQ-016 SHALL discard any sync2 excursion shorter than DB_CYCLES cycles; btn_stable unchanged, cnt returns to 0.
REQ-017 SHALL assert press[i] for exactly the one cycle following the edge where btn_stable[i] goes 0->1; 0 otherwise; no pulse on release.
REQ-018 SHALL toggle mask[i] on the same edge btn_stable[i] goes 0->1.
REQ-019 SHALL clear all mask bits on any edge with clr_all=1; clr_all has priority over a simultaneous toggle.
REQ-020 SHALL leave btn_stable, cnt and press unaffected by clr_all.
REQ-021 SHALL process the four channels independently; simultaneous presses toggle each affected bit in the same cycle.
REQ-022 SHALL never wrap cnt; it never exceeds DB_CYCLES-1.
REQ-023 SHALL keep a held button from re-toggling; another toggle requires release acceptance then a new press acceptance.

Reset
REQ-024 SHALL, on any edge with rst=1, load sync1, sync2, cnt, btn_stable, press and mask with 0.
REQ-025 SHALL give rst priority over clr_all and all debounce activity; a press in progress at reset is discarded.
REQ-026 SHALL, if btn is held high through reset release, accept it as a new press DB_CYCLES+2 edges after the first edge with rst=0.

Verification (DB_CYCLES=4)
REQ-027 SHALL cover: rst high 3 cycles, btn=0 -> all outputs 0.
REQ-028 SHALL cover: btn[0] 0->1 before edge k, held -> btn_stable[0]=1 and mask[0]=1 after edge k+5, press=0001 for one cycle, mask stays 0001 while held.
REQ-029 SHALL cover: btn[2] high for 3 cycles then low -> btn_stable, press, mask unchanged (all 0).
REQ-030 SHALL cover: two full press/release cycles on btn[1] -> mask[1] goes 1 then 0, exactly two press[1] pulses.
REQ-031 SHALL cover: btn=1111 held, clr_all=1 on the accepting edge -> mask=0000, press=1111, btn_stable=1111.
REQ-032 SHALL cover: rst asserted with cnt[3]=2 mid-debounce, btn[3] held -> all 0 during reset; btn_stable[3]=1 and mask[3]=1 six edges after first rst=0 edge.
